// File: rtl/fdc_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fdc_sd_arbiter_if
//  Purpose  : Bundles the per-drive SD block channels of the floppy
//             controller and the single host SD block channel that the
//             arbiter joins together.
//  Signals  : drv_lba/drv_rd/drv_wr/drv_buff_din  drive -> arbiter
//             drv_ack/drv_buff_wr                  arbiter -> drive
//             sd_lba/sd_rd/sd_wr/sd_buff_din       arbiter -> host
//             sd_ack/sd_buff_wr                    host -> arbiter
//  Modports : slave  - the arbiter's view
//             master - the surrounding system (drives plus host)
//  Revision : 1.0  initial release
// ============================================================================
interface fdc_sd_arbiter_if #(
  parameter int NDRV = 4
);
  // Drive side
  logic [NDRV-1:0][31:0] drv_lba;
  logic [NDRV-1:0]       drv_rd;
  logic [NDRV-1:0]       drv_wr;
  logic [NDRV-1:0]       drv_ack;
  logic [NDRV-1:0][7:0]  drv_buff_din;
  logic [NDRV-1:0]       drv_buff_wr;

  // Host side
  logic [31:0]           sd_lba;
  logic                  sd_rd;
  logic                  sd_wr;
  logic                  sd_ack;
  logic                  sd_buff_wr;
  logic [7:0]            sd_buff_din;

  modport slave (
    input  drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
    output drv_ack, drv_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport master (
    output drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
    input  drv_ack, drv_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface
`default_nettype wire

// File: rtl/fdc_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fdc_sd_arbiter
//  Purpose  : Round-robin arbiter that lets NDRV floppy drive channels share
//             one host SD block channel. One drive is served at a time; its
//             LBA and direction are latched at grant, the host request is
//             raised, and the host ack / write strobe / write data are routed
//             only between the host and the granted drive. A request that
//             the host never acks is aborted after TIMEOUT cycles and flagged.
//  Ports    : CLK          system clock, rising edge
//             RESET        synchronous reset, active-high
//             bus          fdc_sd_arbiter_if.slave (drive + host channels)
//             busy         1 whenever the arbiter is not idle
//             grant        index of the granted / last granted drive
//             timeout_err  sticky abort flag, cleared by the next good ack
//  Revision : 1.0  initial release
// ============================================================================
module fdc_sd_arbiter #(
  parameter int          NDRV    = 4,            // 2..4 drive channels
  parameter logic [23:0] TIMEOUT = 24'd5000000   // 0 disables the abort
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  fdc_sd_arbiter_if.slave     bus,
  output logic                busy,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0]  c_ndrv      = 3'(NDRV);
  localparam logic        c_tmo_en    = (TIMEOUT != 24'd0);
  localparam logic [23:0] c_tmo_last  = TIMEOUT - 24'd1;
  localparam logic [23:0] c_timer_max = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_XFER     = 2'd2,
    S_WAIT_REQ = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [1:0]  r_ptr;       // first drive to look at on the next arbitration
  logic [1:0]  r_grant;
  logic        r_dir;       // 1 = write, 0 = read
  logic [31:0] r_lba;
  logic        r_sd_rd;
  logic        r_sd_wr;
  logic [23:0] r_timer;
  logic        r_terr;

  // --------------------------------------------------------------------------
  // Per-drive inputs widened to four lanes so the 2-bit pointer and grant can
  // index them for any NDRV; lanes beyond NDRV read as idle.
  // --------------------------------------------------------------------------
  logic [3:0]        w_req;
  logic [3:0]        w_wr;
  logic [3:0][31:0]  w_lba;
  logic [3:0][7:0]   w_din;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NDRV) begin : g_used
      assign w_req[i] = bus.drv_rd[i] | bus.drv_wr[i];
      assign w_wr[i]  = bus.drv_wr[i];
      assign w_lba[i] = bus.drv_lba[i];
      assign w_din[i] = bus.drv_buff_din[i];
    end else begin : g_unused
      assign w_req[i] = 1'b0;
      assign w_wr[i]  = 1'b0;
      assign w_lba[i] = 32'd0;
      assign w_din[i] = 8'd0;
    end
  end

  // Modulo-NDRV wrap of a small sum (pointer + offset never reaches 2*NDRV).
  function automatic logic [1:0] f_wrap(input logic [2:0] v);
    logic [2:0] r;
    r = (v >= c_ndrv) ? (v - c_ndrv) : v;
    return r[1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin pick: first requesting drive at r_ptr, r_ptr+1, ... mod NDRV
  // --------------------------------------------------------------------------
  logic       w_any;
  logic [1:0] w_pick;
  logic [1:0] w_cand;

  always_comb begin
    w_any  = 1'b0;
    w_pick = 2'd0;
    w_cand = 2'd0;
    for (int k = 0; k < NDRV; k++) begin
      w_cand = f_wrap({1'b0, r_ptr} + 3'(k));
      if (!w_any && w_req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_grant <= 2'd0;
      r_dir   <= 1'b0;
      r_lba   <= 32'd0;
      r_sd_rd <= 1'b0;
      r_sd_wr <= 1'b0;
      r_timer <= 24'd0;
      r_terr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_lba   <= w_lba[w_pick];
            r_dir   <= w_wr[w_pick];   // write wins when both are raised
            r_timer <= 24'd0;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (r_timer != c_timer_max) begin
            r_timer <= r_timer + 24'd1;
          end
          if (bus.sd_ack) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_terr  <= 1'b0;
            r_state <= S_XFER;
          end else if (c_tmo_en && (r_timer == c_tmo_last)) begin
            // Abort; the drive still requests and is re-arbitrated from
            // the next drive onward.
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_terr  <= 1'b1;
            r_ptr   <= f_wrap({1'b0, r_grant} + 3'd1);
            r_state <= S_IDLE;
          end else begin
            r_sd_rd <= ~r_dir;
            r_sd_wr <= r_dir;
          end
        end

        S_XFER: begin
          if (!bus.sd_ack) begin
            r_state <= S_WAIT_REQ;
          end
        end

        S_WAIT_REQ: begin
          // Hold off re-arbitration until the served drive has dropped its
          // request, otherwise a slow drive would be serviced twice.
          if (!w_req[r_grant]) begin
            r_ptr   <= f_wrap({1'b0, r_grant} + 3'd1);
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs and routing
  // --------------------------------------------------------------------------
  logic w_acked;   // host ack has been accepted for the current grant
  logic w_xfer;

  assign w_acked = (r_state == S_XFER) || (r_state == S_WAIT_REQ);
  assign w_xfer  = (r_state == S_XFER);

  always_comb begin
    bus.drv_ack     = '0;
    bus.drv_buff_wr = '0;
    for (int i = 0; i < NDRV; i++) begin
      bus.drv_ack[i]     = bus.sd_ack     & w_acked & (r_grant == 2'(i));
      bus.drv_buff_wr[i] = bus.sd_buff_wr & w_xfer  & (r_grant == 2'(i));
    end
  end

  assign bus.sd_lba      = r_lba;
  assign bus.sd_rd       = r_sd_rd;
  assign bus.sd_wr       = r_sd_wr;
  assign bus.sd_buff_din = w_din[r_grant];

  assign busy        = (r_state != S_IDLE);
  assign grant       = r_grant;
  assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: doc/fdc_sd_arbiter.md
Name: fdc_sd_arbiter

Overview:
Sits between the four-drive floppy controller's per-drive SD block interfaces (4 x lba/rd/wr/ack/buff_din) and a single host SD block channel.
- Grants one drive at a time, round-robin.
- Latches the granted drive's LBA and direction, and drives the host request.
- Routes the host ack, buffer write strobe and write data between the host and the granted drive only.
- Provides a request timeout and status for diagnostics.

Parameters:
NDRV, 4, number of drive channels (2..4); the pointer is always 2 bits.
TIMEOUT, 24'd5000000, CLK cycles from host request to host ack rise before abort; 0 disables the timeout.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RESET  input  1  synchronous reset, active-high.
drv_lba  input  32 x NDRV  per-drive block address.
drv_rd  input  NDRV  per-drive read request; level, held until the drive sees its ack.
drv_wr  input  NDRV  per-drive write request; level.
drv_ack  output  NDRV  per-drive ack; only the granted bit can be 1.
drv_buff_din  input  8 x NDRV  per-drive write data toward the host.
drv_buff_wr  output  NDRV  per-drive buffer write strobe; the host strobe gated to the granted drive.
sd_lba  output  32  host LBA, registered.
sd_rd  output  1  host read request.
sd_wr  output  1  host write request.
sd_ack  input  1  host ack; high during the transfer.
sd_buff_wr  input  1  host buffer write strobe.
sd_buff_din  output  8  write data to the host, muxed from the granted drive.
busy  output  1  1 in any state other than IDLE.
grant  output  2  index of the granted or last granted drive.
timeout_err  output  1  sticky; set on abort, cleared by RESET or by the next successful ack.

Behaviour:
- Reset (RESET=1 at a rising edge), all synchronous:
  - state=IDLE, pointer=0, grant=0.
  - sd_rd=0, sd_wr=0, sd_lba=0, drv_ack=0, timeout_err=0, timer=0.
  - Reset mid-transfer drops the host request immediately; no drive sees ack afterward.
- Combinational routing:
  - drv_ack[i] = sd_ack & (state==XFER | state==WAIT_REQ) & (grant==i).
  - drv_buff_wr[i] = sd_buff_wr & (grant==i) & (state==XFER).
  - sd_buff_din = drv_buff_din[grant].
- Request vector: req[i] = drv_rd[i] | drv_wr[i], for i < NDRV.
- IDLE:
  - If any req, pick the first set bit searching pointer, pointer+1, ... modulo NDRV.
  - Register grant=i, sd_lba=drv_lba[i], dir = drv_wr[i] (write wins if rd and wr are both set).
  - Clear timer; go to ISSUE. Latency from request to host request = 2 cycles.
- ISSUE:
  - sd_rd = ~dir, sd_wr = dir, held while waiting; timer increments.
  - sd_ack=1 -> clear sd_rd/sd_wr the same edge, clear timeout_err, go to XFER.
  - TIMEOUT!=0 and timer==TIMEOUT-1 without ack -> clear request, set timeout_err, pointer=grant+1, go to IDLE.
  - The aborted drive keeps requesting and is re-arbitrated later.
- XFER:
  - Host streams the block (512 bytes) while sd_ack=1.
  - sd_ack falls -> go to WAIT_REQ.
- WAIT_REQ:
  - Wait until req[grant]==0, i.e. the drive has dropped its request after seeing ack.
  - Then pointer = grant+1 mod NDRV; go to IDLE.
  - This prevents double-servicing a drive whose request deasserts late.
- Held constant from grant until IDLE: sd_lba and dir. drv_lba changes after grant are ignored.
- Fairness: with all drives requesting continuously, service order is 0,1,2,3,0...
- sd_ack high in IDLE (stale) is ignored; no drv_ack is produced.
- timer: 24 bits, saturating; it never wraps.

Test Plan:
1. Single read: drv_rd[2]=1, drv_lba[2]=32'h123. Expect:
   - grant=2, sd_lba=32'h123, sd_rd=1 two cycles later.
   - Host acks 600 cycles: drv_ack=4'b0100 only; sd_rd=0 on the ack edge.
   - Drop drv_rd[2] -> IDLE, busy=0.
2. Write routing: drv_wr[1]=1, drv_buff_din[1]=8'hA5, others 8'h00. Expect:
   - sd_wr=1.
   - During ack, sd_buff_din=8'hA5.
   - 512 host sd_buff_wr pulses appear only on drv_buff_wr[1].
3. Round-robin: all four drives request simultaneously and re-request after each service. Expect grant sequence 0,1,2,3,0.
4. Timeout: TIMEOUT=16, drv_rd[3]=1, no ack. Expect:
   - sd_rd drops after 16 cycles; timeout_err=1.
   - Re-grant of drive 3 after the pointer wraps.
   - A later successful ack clears timeout_err.
5. Reset mid-transfer: RESET=1 during XFER with sd_ack=1. Expect next cycle: drv_ack=0, sd_rd=sd_wr=0, grant=0, state IDLE.
6. Late release: drive 0 holds drv_rd 20 cycles after ack falls while drive 1 requests. Expect no second host request for drive 0; drive 1 granted after drive 0 deasserts.
